instruction_memory_rw: RTL and testbench
========================================

Name: instruction_memory_rw

Overview:
Parametrised, synchronous successor to the combinational instruction store: a word-organised RAM of MIPS instructions with a byte-addressed fetch port and a program-load port.
- After reset, an init state machine clears every word to zero before fetches are accepted.
- Fetch is registered (1-cycle latency) with a valid/fault handshake.
- Sits between the PC stage and decode; the load port is driven by the testbench or boot loader.

Parameters:
DEPTH, 64, number of 32-bit instruction words (power of two, >=2)
AW, 6, word-index width = log2(DEPTH)
DATA_W, 32, instruction width (fixed 32 for MIPS; exposed for bench reuse)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
fetch_req  in  1  fetch request, sampled at clk edge
fetch_addr  in  32  byte address (PC)
fetch_valid  out  1  fetch_data/fetch_fault valid this cycle
fetch_data  out  DATA_W  fetched instruction
fetch_fault  out  1  request was misaligned or out of range
ready  out  1  init complete; fetch and load accepted
load_we  in  1  program-load write enable
load_addr  in  32  byte address of word to write
load_data  in  DATA_W  instruction to write
load_err  out  1  pulse: rejected load (misaligned, out of range, or not ready)

Behaviour:
Reset and initialisation
- rst asserted (async): state=INIT, init counter=0, ready=0, fetch_valid=0, fetch_data=0, fetch_fault=0, load_err=0.
- Array contents are not reset directly.
- INIT: each cycle writes 0 to word[counter] and increments the counter. After writing word DEPTH-1, go to READY with ready=1 on the next cycle.
- INIT therefore lasts exactly DEPTH cycles after rst deassert.
- rst asserted mid-INIT or mid-READY: immediately return to INIT at counter 0; any in-flight fetch result is dropped (fetch_valid=0).
- States are INIT and READY only. READY persists until rst.

Address decode (same rules on both ports)
- Word index = addr[AW+1:2].
- Misaligned: addr[1:0] != 0.
- Out of range: addr[31:AW+2] != 0.

Fetch (READY only)
- Request accepted when fetch_req=1 at edge N.
- At N+1: fetch_valid=1.
  - Legal address: fetch_data=word[index], fetch_fault=0.
  - Misaligned or out-of-range: fetch_data=0, fetch_fault=1.
- fetch_req=0: fetch_valid=0 next cycle. fetch_data holds its last value; fetch_fault=0.
- Back-to-back requests give one result per cycle (fully pipelined, no bubbles).
- fetch_req in INIT is ignored: no valid, no fault.

Load
- load_we=1 in READY with a legal address: word[index]<=load_data at that edge.
- Illegal address, or load_we=1 while not ready: no write; load_err=1 for exactly the next cycle.
- Simultaneous fetch and load to the same word in the same cycle: fetch returns the OLD contents (read-first). The new value is visible from the following request.
- Load and fetch to different words in the same cycle: both proceed independently.

Width rules
- Only fetch_addr/load_addr bits [AW+1:0] index the array; upper bits are used only for range checking.
- No arithmetic wrap: an out-of-range address faults rather than aliasing to a lower word.

Test Plan:
1. Init: DEPTH=64, release rst at cycle 0 -> ready=0 for cycles 0..63, ready=1 at cycle 64; fetch of 0x0,0x4,...,0xFC then returns 0x00000000 with fault=0.
2. Load/fetch program: load 0x20000003@0x0, 0x20210004@0x4, 0xAC010000@0x8; then fetch_req with 0x0,0x4,0x8 on consecutive cycles -> fetch_valid=1 for 3 consecutive cycles, data 0x20000003, 0x20210004, 0xAC010000.
3. Faults: fetch 0x6 -> valid=1, fault=1, data=0. Fetch 0x100 with DEPTH=64 -> fault=1, data=0. Load to 0x2 -> load_err pulses 1 cycle and word 0 is unchanged.
4. Read-first collision: word[3]=0x11111111; same cycle load 0x22222222@0xC and fetch 0xC -> data=0x11111111; next fetch 0xC -> 0x22222222.
5. Not-ready accesses: during INIT, fetch_req=1 -> fetch_valid stays 0; load_we=1 -> load_err=1 and no write occurs (word still 0 after INIT).
6. Reset mid-operation: assert rst for 1 cycle while a fetch is pending -> fetch_valid=0 and ready=0 immediately; INIT reruns for DEPTH cycles; previously loaded words read 0x00000000 afterwards.

Source files
------------

// File: rtl/instruction_memory_rw.sv
// Word-organised MIPS instruction RAM with a registered byte-addressed fetch port and a program-load port.
// After reset an init sequencer zeroes every word before fetches or loads are accepted.
module instruction_memory_rw #(
  parameter int DEPTH  = 64,
  parameter int AW     = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  output logic              ready,
  input  logic              load_we,
  input  logic [31:0]       load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err
);

  typedef enum logic {INIT, READY} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     init_cnt, init_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_p1;
  logic              fault_p1;
  logic [DATA_W-1:0] data_p1;
  logic              load_err_p1;
  logic              fetch_acc;
  logic              load_ok;

  // Upper bits only range-check; an out-of-range address never aliases onto a low word.
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == INIT) begin
      init_cnt_nxt = init_cnt + 1'b1;
      if (init_cnt == AW'(DEPTH - 1)) state_nxt = READY;
    end
  end

  assign ready     = (state == READY);
  assign fetch_acc = fetch_req && ready;
  assign load_ok   = load_we && ready && addr_legal(load_addr);

  // Single write port: the init sweep owns it until ready, then the load port.
  always_ff @(posedge clk) begin
    if (!ready)
      mem[init_cnt] <= '0;
    else if (load_ok)
      mem[word_idx(load_addr)] <= load_data;
  end

  // Stage p0 -> p1: registered read; a same-edge load is seen only by later requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      fault_p1    <= 1'b0;
      data_p1     <= '0;
      load_err_p1 <= 1'b0;
    end else begin
      vld_p1      <= fetch_acc;
      fault_p1    <= fetch_acc && !addr_legal(fetch_addr);
      load_err_p1 <= load_we && !load_ok;
      if (fetch_acc)
        data_p1 <= addr_legal(fetch_addr) ? mem[word_idx(fetch_addr)] : '0;
    end
  end

  assign fetch_valid = vld_p1;
  assign fetch_fault = fault_p1;
  assign fetch_data  = data_p1;
  assign load_err    = load_err_p1;

endmodule

// File: tb/tb_instruction_memory_rw.sv
// Scoreboard bench for instruction_memory_rw: directed fetch/load vectors push expected
// results into a queue that a negedge monitor drains whenever fetch_valid is high.
module tb_instruction_memory_rw;

  localparam int DEPTH  = 64;
  localparam int AW     = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_fault;
  logic              ready;
  logic              load_we;
  logic [31:0]       load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [31:0] last_data = '0;

  instruction_memory_rw #(.DEPTH(DEPTH), .AW(AW), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .ready(ready),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented result must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fetch_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_fetch_valid: got=1 expected=0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("fetch_data", fetch_data, e.data);
          chk("fetch_fault", 32'(fetch_fault), 32'(e.fault));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic f);
    fetch_req  = 1'b1;
    fetch_addr = a;
    sb.push_back('{data: d, fault: f});
    tick();
    chk("fetch_valid", 32'(fetch_valid), 32'd1);
    last_data = d;
  endtask

  task automatic idle();
    fetch_req = 1'b0;
    load_we   = 1'b0;
    tick();
    chk("idle_valid", 32'(fetch_valid), 32'd0);
    chk("idle_fault", 32'(fetch_fault), 32'd0);
    chk("idle_data_hold", fetch_data, last_data);
    chk("idle_load_err", 32'(load_err), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic err);
    fetch_req = 1'b0;
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_we = 1'b0;
    chk("load_err", 32'(load_err), 32'(err));
  endtask

  task automatic run_init(input bit poke);
    int n;
    n = 0;
    chk("init_ready_low", 32'(ready), 32'd0);
    if (poke) begin
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      load_we    = 1'b1;
      load_addr  = 32'h10;
      load_data  = 32'hDEADBEEF;
      tick();
      fetch_req = 1'b0;
      load_we   = 1'b0;
      chk("init_fetch_ignored", 32'(fetch_valid), 32'd0);
      chk("init_load_err", 32'(load_err), 32'd1);
      tick();
      chk("init_load_err_pulse", 32'(load_err), 32'd0);
      n = 2;
    end
    repeat (DEPTH - 1 - n) tick();
    chk("ready_after_63", 32'(ready), 32'd0);
    tick();
    chk("ready_after_64", 32'(ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_we    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_data", fetch_data, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    rst = 1'b0;

    // Init sweep, with fetch/load attempts while not ready
    run_init(1'b1);
    for (int i = 0; i < DEPTH; i++) do_fetch(32'(i * 4), 32'h0, 1'b0);
    idle();

    // Program load and back-to-back fetch
    do_load(32'h0, 32'h20000003, 1'b0);
    do_load(32'h4, 32'h20210004, 1'b0);
    do_load(32'h8, 32'hAC010000, 1'b0);
    do_fetch(32'h0, 32'h20000003, 1'b0);
    do_fetch(32'h4, 32'h20210004, 1'b0);
    do_fetch(32'h8, 32'hAC010000, 1'b0);
    idle();

    // Faults on both ports
    do_fetch(32'h6, 32'h0, 1'b1);
    do_fetch(32'h100, 32'h0, 1'b1);
    do_fetch(32'h8000_0000, 32'h0, 1'b1);
    idle();
    do_load(32'h2, 32'hFFFFFFFF, 1'b1);
    do_load(32'h100, 32'hEEEEEEEE, 1'b1);
    idle();
    do_fetch(32'h0, 32'h20000003, 1'b0);
    idle();

    // Read-first collision, then independent load/fetch to different words
    do_load(32'hC, 32'h11111111, 1'b0);
    load_we   = 1'b1;
    load_addr = 32'hC;
    load_data = 32'h22222222;
    do_fetch(32'hC, 32'h11111111, 1'b0);
    load_we = 1'b0;
    chk("collision_load_err", 32'(load_err), 32'd0);
    do_fetch(32'hC, 32'h22222222, 1'b0);
    load_we   = 1'b1;
    load_addr = 32'h14;
    load_data = 32'h33333333;
    do_fetch(32'h8, 32'hAC010000, 1'b0);
    load_we = 1'b0;
    do_fetch(32'h14, 32'h33333333, 1'b0);
    idle();

    // Reset while a fetch result is on the outputs
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    tick();
    #1;
    rst       = 1'b1;
    fetch_req = 1'b0;
    #1;
    chk("midrst_valid", 32'(fetch_valid), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_data", fetch_data, 32'd0);
    last_data = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_init(1'b0);
    do_fetch(32'h0, 32'h0, 1'b0);
    do_fetch(32'h4, 32'h0, 1'b0);
    do_fetch(32'h8, 32'h0, 1'b0);
    do_fetch(32'hC, 32'h0, 1'b0);
    do_fetch(32'h14, 32'h0, 1'b0);
    idle();

    repeat (2) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
